// File: rtl/pwm_multi_if.sv
// Control and output bundle of pwm_multi: run/load strobes, period/duty words and the PWM outputs.
interface pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  logic                      en;
  logic                      load;
  logic [CNT_W-1:0]          period;
  logic [CHANNELS*CNT_W-1:0] duty;
  logic                      center;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_end;

  modport master (
    output en, load, period, duty, center,
    input  pwm_out, period_end
  );

  modport slave (
    input  en, load, period, duty, center,
    output pwm_out, period_end
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM from one shared counter; period/duty double-buffered and swapped at period boundaries. Outputs registered, 1 cycle after cnt; no backpressure.
// PWM_CENTER_ALIGN_EN adds center-aligned (up/down) counting selected by the center input.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus
);

  logic [CNT_W-1:0]    sh_per_q;
  logic [CNT_W-1:0]    act_per_q;
  logic [CNT_W-1:0]    sh_duty_q  [CHANNELS];
  logic [CNT_W-1:0]    act_duty_q [CHANNELS];
  logic                pending_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    pe_last;
  logic                boundary;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q;

  // Last count of the period; a programmed period of 0 behaves as 1.
  assign pe_last = (act_per_q == '0) ? '0 : act_per_q - CNT_W'(1);

`ifdef PWM_CENTER_ALIGN_EN
  logic dn_q, dn_d;
  logic mode_q;

  always_comb begin
    cnt_d    = cnt_q;
    dn_d     = dn_q;
    boundary = 1'b1;
    if (!bus.en) begin
      cnt_d = '0;
      dn_d  = 1'b0;
    end else if (mode_q) begin
      boundary = dn_q && (cnt_q == '0);
      if (boundary) begin
        cnt_d = '0;
        dn_d  = 1'b0;
      end else if (!dn_q) begin
        // Top of the triangle is held for one cycle while the direction flips.
        if (cnt_q >= pe_last) dn_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      boundary = (cnt_q >= pe_last);
      cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
      dn_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dn_q   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      dn_q <= dn_d;
      if (boundary) mode_q <= bus.center;
    end
  end
`else
  logic unused_center;
  assign unused_center = bus.center;

  always_comb begin
    boundary = !bus.en || (cnt_q >= pe_last);
    cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
  end
`endif

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = bus.en && (cnt_q < act_duty_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_per_q     <= '0;
      act_per_q    <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_duty_q[i]  <= '0;
        act_duty_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      period_end_q <= bus.en && boundary;
      if (bus.load) begin
        sh_per_q <= bus.period;
        for (int i = 0; i < CHANNELS; i++) sh_duty_q[i] <= bus.duty[i*CNT_W +: CNT_W];
      end
      // A load landing on the boundary bypasses the shadow bank.
      if (boundary && bus.load) begin
        act_per_q <= bus.period;
        for (int i = 0; i < CHANNELS; i++) act_duty_q[i] <= bus.duty[i*CNT_W +: CNT_W];
        pending_q <= 1'b0;
      end else if (boundary && pending_q) begin
        act_per_q <= sh_per_q;
        for (int i = 0; i < CHANNELS; i++) act_duty_q[i] <= sh_duty_q[i];
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.period_end = period_end_q;

endmodule
